dcache_stall: RTL and testbench

//  Parametrised set-associative data cache for the M stage of the 5-stage core.

---
 rtl/dcache_stall_pkg.sv | 28 ++
 rtl/dcache_stall_if.sv | 29 ++
 rtl/dcache_stall_way_array.sv | 47 ++++
 rtl/dcache_stall.sv | 196 +++++++++++++++++++
 tb/tb_dcache_stall.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/dcache_stall_pkg.sv
// Shared types and address-field width helpers for the set-associative stalling data cache.
package dcache_stall_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StWrite = 2'd2
  } state_e;

  function automatic int unsigned offset_w(input int unsigned line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int unsigned index_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned sets,
                                        input int unsigned line_words);
    return addr_w - index_w(sets) - offset_w(line_words);
  endfunction

  // Word-select width; kept at least 1 so single-word lines still have a legal vector.
  function automatic int unsigned word_w(input int unsigned line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/dcache_stall_if.sv
// Core-side request/response and backing-memory handshake bundle for dcache_stall.
interface dcache_stall_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rsp_rdata;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output rsp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  rsp_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/dcache_stall_way_array.sv
// One cache way: tag/valid/data storage with combinational read and synchronous write.
module dcache_stall_way_array
  import dcache_stall_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 24,
  localparam int unsigned IDX_W     = index_w(SETS),
  localparam int unsigned WORD_W    = word_w(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [WORD_W-1:0] i_rd_word,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_valid,
  output logic [31:0]       o_rdata,
  input  logic              i_data_we,
  input  logic [WORD_W-1:0] i_wr_word,
  input  logic [31:0]       i_wdata,
  input  logic              i_tag_we,
  input  logic [TAG_W-1:0]  i_tag
);

  logic [31:0]      r_data [SETS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [SETS-1:0]  r_valid;

  assign o_tag   = r_tag[i_index];
  assign o_valid = r_valid[i_index];
  assign o_rdata = r_data[i_index][i_rd_word];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_tag_we) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Payload storage needs no reset: nothing is visible until its valid bit is set.
  always_ff @(posedge clk) begin
    if (i_data_we) r_data[i_index][i_wr_word] <= i_wdata;
    if (i_tag_we)  r_tag[i_index] <= i_tag;
  end

endmodule

// File: rtl/dcache_stall.sv
// Write-through, no-write-allocate set-associative data cache that stalls the core on
// load misses and stores while the backing memory request is outstanding.
module dcache_stall
  import dcache_stall_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input logic           clk,
  input logic           rst_n,
  dcache_stall_if.slave bus
);

  localparam int unsigned OFFSET_W = offset_w(LINE_WORDS);
  localparam int unsigned IDX_W    = index_w(SETS);
  localparam int unsigned TAG_W    = tag_w(ADDR_W, SETS, LINE_WORDS);
  localparam int unsigned WORD_W   = word_w(LINE_WORDS);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);

  state_e            r_state, w_state_d;
  logic [WORD_W-1:0] r_word_cnt, w_word_cnt_d;
  logic              r_victim, w_victim_d;
  logic              r_post_fill, w_post_fill_d;
  logic [SETS-1:0]   r_lru;
  logic              w_lru_we, w_lru_val;
  logic [31:0]       r_hit_count, r_miss_count;
  logic              w_hit_inc, w_miss_inc;

  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [WORD_W-1:0] w_word;
  logic [ADDR_W-1:0] w_line_base;
  logic [TAG_W-1:0]  w_way_tag   [WAYS];
  logic [31:0]       w_way_rdata [WAYS];
  logic [WAYS-1:0]   w_way_valid;
  logic [WAYS-1:0]   w_hit;
  logic              w_hit_any, w_hit_way, w_victim, w_stall;
  logic [31:0]       w_hit_rdata;
  logic [WAYS-1:0]   w_data_we, w_tag_we;
  logic [WORD_W-1:0] w_wr_word;
  logic [31:0]       w_wr_data;
  logic              w_unused;

  assign w_index     = bus.req_addr[OFFSET_W +: IDX_W];
  assign w_tag       = bus.req_addr[OFFSET_W + IDX_W +: TAG_W];
  assign w_word      = (LINE_WORDS > 1) ? bus.req_addr[2 +: WORD_W] : '0;
  assign w_line_base = {bus.req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign w_unused    = ^bus.req_addr[1:0];

  for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
    dcache_stall_way_array #(
      .SETS      (SETS),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_index  (w_index),
      .i_rd_word(w_word),
      .o_tag    (w_way_tag[gw]),
      .o_valid  (w_way_valid[gw]),
      .o_rdata  (w_way_rdata[gw]),
      .i_data_we(w_data_we[gw]),
      .i_wr_word(w_wr_word),
      .i_wdata  (w_wr_data),
      .i_tag_we (w_tag_we[gw]),
      .i_tag    (w_tag)
    );
    assign w_hit[gw] = w_way_valid[gw] && (w_way_tag[gw] == w_tag);
  end

  assign w_hit_any = |w_hit;

  always_comb begin
    w_hit_way   = 1'b0;
    w_hit_rdata = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_hit[w]) begin
        w_hit_way   = 1'(w);
        w_hit_rdata = w_way_rdata[w];
      end
    end
  end

  // First invalid way wins (way 0 first); with both valid the set's LRU bit decides.
  always_comb begin
    w_victim = 1'b0;
    if (WAYS > 1 && w_way_valid[0]) begin
      w_victim = w_way_valid[WAYS-1] ? r_lru[w_index] : 1'b1;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_word_cnt_d  = r_word_cnt;
    w_victim_d    = r_victim;
    w_post_fill_d = 1'b0;
    w_stall       = 1'b0;
    w_lru_we      = 1'b0;
    w_lru_val     = 1'b0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    w_data_we     = '0;
    w_tag_we      = '0;
    w_wr_word     = w_word;
    w_wr_data     = bus.req_wdata;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {bus.req_addr[ADDR_W-1:2], 2'b00};
    bus.mem_wdata = bus.req_wdata;

    unique case (r_state)
      StIdle: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            w_stall   = 1'b1;
            w_state_d = StWrite;
          end else if (w_hit_any) begin
            // The re-hit right after a fill belongs to an already-counted miss.
            w_hit_inc = !r_post_fill;
            w_lru_we  = 1'b1;
            w_lru_val = ~w_hit_way;
          end else begin
            w_stall      = 1'b1;
            w_miss_inc   = 1'b1;
            w_victim_d   = w_victim;
            w_word_cnt_d = '0;
            w_state_d    = StFill;
          end
        end
      end

      StFill: begin
        w_stall      = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = w_line_base | (ADDR_W'(r_word_cnt) << 2);
        if (bus.mem_ack) begin
          w_data_we[r_victim] = 1'b1;
          w_wr_word           = r_word_cnt;
          w_wr_data           = bus.mem_rdata;
          if (r_word_cnt == LAST_WORD) begin
            w_tag_we[r_victim] = 1'b1;
            w_lru_we           = 1'b1;
            w_lru_val          = ~r_victim;
            w_post_fill_d      = 1'b1;
            w_state_d          = StIdle;
          end else begin
            w_word_cnt_d = r_word_cnt + 1'b1;
          end
        end
      end

      StWrite: begin
        w_stall     = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          w_stall   = 1'b0;
          w_data_we = w_hit_any ? (WAYS'(1) << w_hit_way) : '0;
          w_state_d = StIdle;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  // Stall is forced low under reset since a held load miss would otherwise assert it.
  assign bus.stall      = w_stall && rst_n;
  assign bus.rsp_rdata  = w_hit_rdata;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_word_cnt   <= '0;
      r_victim     <= 1'b0;
      r_post_fill  <= 1'b0;
      r_lru        <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state     <= w_state_d;
      r_word_cnt  <= w_word_cnt_d;
      r_victim    <= w_victim_d;
      r_post_fill <= w_post_fill_d;
      if (w_lru_we) r_lru[w_index] <= w_lru_val;
      if (w_hit_inc && (r_hit_count != '1)) r_hit_count <= r_hit_count + 32'd1;
      if (w_miss_inc && (r_miss_count != '1)) r_miss_count <= r_miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_stall.sv
// Directed bench for dcache_stall: table of accesses against a fixed-latency memory model,
// plus a hand sequence for reset during a line fill.
module tb_dcache_stall;

  localparam int LAT = 3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_stall_if #(.ADDR_W(32)) bus ();

  dcache_stall #(
    .SETS      (16),
    .WAYS      (2),
    .LINE_WORDS(4),
    .ADDR_W    (32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [4096];
  logic [31:0] rd_addrs [$];
  int          lat_cnt = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          n_pass = 0;
  int          n_checks = 0;
  vec_t        vecs [13];

  // Memory model: acks on the LAT-th cycle of each request.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (lat_cnt == LAT - 1) begin
        lat_cnt     = 0;
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem[bus.mem_addr[13:2]] = bus.mem_wdata;
          wr_cnt++;
        end else begin
          bus.mem_rdata = mem[bus.mem_addr[13:2]];
          rd_cnt++;
          rd_addrs.push_back(bus.mem_addr);
        end
      end else begin
        lat_cnt++;
        bus.mem_ack = 1'b0;
      end
    end else begin
      lat_cnt     = 0;
      bus.mem_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int stalls);
    int c;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    stalls = 0;
    for (c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (!bus.stall) break;
      stalls++;
    end
    rdata = bus.rsp_rdata;
    if (c == 100) check("access_timeout", 32'(c), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rdata;
    int          stalls, r0, w0, q0;
    bit          found;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[32'h100 >> 2] = 32'hA5A5_0001;

    //             we    addr          wdata         rdata         stl rd wr hits  misses
    vecs[0]  = '{1'b0, 32'h0000_0100, 32'h0,        32'hA5A5_0001, 13, 4, 0, 32'd0, 32'd1};
    vecs[1]  = '{1'b0, 32'h0000_0104, 32'h0,        32'hC0DE_0041, 0,  0, 0, 32'd1, 32'd1};
    vecs[2]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0,        3,  0, 1, 32'd1, 32'd1};
    vecs[3]  = '{1'b0, 32'h0000_0108, 32'h0,        32'hDEAD_BEEF, 0,  0, 0, 32'd2, 32'd1};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,        32'hA5A5_0001, 0,  0, 0, 32'd3, 32'd1};
    vecs[5]  = '{1'b0, 32'h0000_0500, 32'h0,        32'hC0DE_0140, 13, 4, 0, 32'd3, 32'd2};
    vecs[6]  = '{1'b0, 32'h0000_0100, 32'h0,        32'hA5A5_0001, 0,  0, 0, 32'd4, 32'd2};
    vecs[7]  = '{1'b0, 32'h0000_0900, 32'h0,        32'hC0DE_0240, 13, 4, 0, 32'd4, 32'd3};
    vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,        32'hA5A5_0001, 0,  0, 0, 32'd5, 32'd3};
    vecs[9]  = '{1'b0, 32'h0000_0500, 32'h0,        32'hC0DE_0140, 13, 4, 0, 32'd5, 32'd4};
    vecs[10] = '{1'b1, 32'h0000_2000, 32'hC0FF_EE00, 32'h0,        3,  0, 1, 32'd5, 32'd4};
    vecs[11] = '{1'b0, 32'h0000_2000, 32'h0,        32'hC0FF_EE00, 13, 4, 0, 32'd5, 32'd5};
    vecs[12] = '{1'b0, 32'h0000_0504, 32'h0,        32'hC0DE_0141, 0,  0, 0, 32'd6, 32'd5};

    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_hits", bus.hit_count, 32'd0);
    check("rst_misses", bus.miss_count, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      q0 = rd_addrs.size();
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, stalls);
      check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
      if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_mem_reads", i), 32'(rd_cnt - r0), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_mem_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_hits", i), bus.hit_count, vecs[i].exp_hits);
      check($sformatf("v%0d_misses", i), bus.miss_count, vecs[i].exp_misses);
      if (vecs[i].exp_rd == 4 && rd_addrs.size() >= q0 + 4) begin
        for (int k = 0; k < 4; k++) begin
          check($sformatf("v%0d_fill_addr%0d", i, k), rd_addrs[q0 + k],
                (vecs[i].addr & ~32'hF) + 32'(4 * k));
        end
      end
    end
    check("store_mem_0x108", mem[32'h108 >> 2], 32'hDEAD_BEEF);

    // Reset asserted during the second fill ack abandons the request at once.
    r0 = rd_cnt;
    found = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_3000;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (bus.mem_ack && rd_cnt == r0 + 2) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_fill_reached", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midfill_mem_req", 32'(bus.mem_req), 32'd0);
    check("midfill_stall", 32'(bus.stall), 32'd0);
    check("midfill_rdata", bus.rsp_rdata, 32'd0);
    check("midfill_hits", bus.hit_count, 32'd0);
    check("midfill_misses", bus.miss_count, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    r0 = rd_cnt;
    access(1'b0, 32'h0000_0100, 32'h0, rdata, stalls);
    check("post_rst_stalls", 32'(stalls), 32'd13);
    check("post_rst_rdata", rdata, 32'hA5A5_0001);
    check("post_rst_reads", 32'(rd_cnt - r0), 32'd4);
    check("post_rst_misses", bus.miss_count, 32'd1);
    check("post_rst_hits", bus.hit_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
